hbram_host_arbiter: RTL and testbench
=====================================

HBRAM_HOST_ARBITER -- requirements
Module: hbram_host_arbiter

Interface
REQ-001 SHALL have parameter RAM_DBW, default 8: HyperRAM DQ width; data = 2*RAM_DBW bits, mask = RAM_DBW/4 bits.
REQ-002 SHALL have parameter RAM_ABW, default 25: host address width.
REQ-003 SHALL have parameter TURN_CYC, default 4: h_req-low gap between bursts (1..15).
REQ-004 SHALL have ports clk in 1 (single clock) and rst in 1 (reset, synchronous, active-high).
REQ-005 SHALL have per-requester ports for N in {0,1}:
- reqN in 1: burst request, level.
- lastN in 1: last word of burst.
- addrN in RAM_ABW: burst start address.
- btypeN in 1: burst type.
- atypeN in 1: access space.
- rwenN in 1: 0 = write, 1 = read.
- wdmN in RAM_DBW/4: write mask.
- wdataN in 2*RAM_DBW: write data.
- gntN out 1: burst granted.
- wrdyN out 1: write accepted.
- rdavN out 1: read data valid.
REQ-006 SHALL have shared outputs rdata out 2*RAM_DBW (read data) and mrdy out 1 (controller ready).
REQ-007 SHALL have controller-side outputs h_req, h_last, h_addr, h_btype, h_atype, h_rwen, h_wdm and h_wdata, and controller-side inputs h_mrdy, h_pause, h_wrdy, h_rdata and h_rdav, with widths per REQ-001/002.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> XFER -> GAP -> IDLE.
REQ-009 In IDLE, SHALL pick a winner only when h_mrdy=1 and h_pause=0; otherwise it SHALL stay in IDLE with no grant.
REQ-010 Arbitration SHALL be round-robin:
- one requester active: that requester wins;
- both active: the requester not served last wins;
- pointer reset value: port 0 has priority.
REQ-011 SHALL register the winner's addr, btype, atype and rwen at the IDLE->ISSUE transition and hold them constant on h_* until GAP ends.
REQ-012 ISSUE SHALL last exactly 1 cycle with h_req=1, so h_req rises 1 cycle after the winning cycle.
REQ-013 gntN SHALL be 1 from ISSUE through XFER for the winner only; at most one gnt SHALL be high.
REQ-014 In XFER, SHALL hold h_req=1 and route the winner's lastN, wdmN and wdataN combinationally to h_last, h_wdm and h_wdata.
REQ-015 In XFER, SHALL drive wrdyN=h_wrdy and rdavN=h_rdav for the winner; the loser's wrdy and rdav SHALL be 0.
REQ-016 rdata SHALL be driven by h_rdata unregistered.
REQ-017 Burst end: in XFER, SHALL take h_last=1 together with (rwen=0 and h_wrdy=1) or (rwen=1 and h_rdav=1) as the final beat; the next cycle SHALL be GAP.
REQ-018 GAP SHALL last TURN_CYC cycles with h_req=0, no grant and the round-robin pointer flipped to the other port; it then SHALL return to IDLE.
REQ-019 A new burst SHALL not issue earlier than IDLE after GAP, giving a minimum h_req-low time of TURN_CYC+1 cycles.
REQ-020 SHALL ignore h_pause asserted during ISSUE or XFER and finish the burst; the pause SHALL block only the next IDLE grant.
REQ-021 If h_mrdy drops during XFER, SHALL go to GAP immediately and then hold in IDLE until h_mrdy=1.
REQ-022 Deassertion of reqN by the granted requester mid-burst SHALL not end the burst; only REQ-017 or REQ-021 SHALL end it.
REQ-023 mrdy SHALL equal h_mrdy & ~h_pause, registered, with 1-cycle latency.

Reset
REQ-024 While rst=1 at a clk edge, SHALL set FSM=IDLE, pointer=port 0, GAP counter=0, and drive h_req, h_last, gnt0, gnt1, mrdy and all wrdy/rdav to 0 and all h_* data/address to 0.
REQ-025 Reset asserted mid-XFER SHALL drop h_req and gnt on the next edge without visiting GAP.

Structure
REQ-026 The FSM state encoding and the TURN_CYC width constant (4 bits) SHALL reside in the shared hbram package.
REQ-027 SHALL use a single sub-module, hbram_rr_arb2 (2-way round-robin picker: req[1:0], pointer -> one-hot winner), and no other hierarchy.

Verification
REQ-028 Bench SHALL cover: req0 only, write of 4 beats -> h_req rises 1 cycle after req0, h_addr=addr0, wrdy0 mirrors h_wrdy, h_req low for 4 cycles after the last beat.
REQ-029 Bench SHALL cover: req0 and req1 held continuously -> gnt order 0,1,0,1 over 4 bursts.
REQ-030 Bench SHALL cover: h_pause=1 in IDLE with req1=1 -> no h_req; h_pause falls -> h_req 1 cycle later.
REQ-031 Bench SHALL cover: h_pause=1 mid-read-burst -> burst completes, rdav1 pulses equal h_rdav count, then no new grant while paused.
REQ-032 Bench SHALL cover: rst=1 in XFER of an 8-beat burst -> next cycle h_req=0, gnt0=gnt1=0, pointer=0.
REQ-033 Bench SHALL cover: h_mrdy falls in XFER -> GAP of TURN_CYC cycles, then hold in IDLE; h_mrdy rises -> grant resumes.

Source files
------------

// File: rtl/hbram_pkg.sv
// Shared HyperRAM host-side constants: arbiter FSM encoding and turnaround counter width.
package hbram_pkg;
  localparam int TURN_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;
endpackage

// File: rtl/hbram_rr_arb2.sv
// Two-way round-robin picker: combinational, one-hot winner; ptr names the port that wins a tie.
module hbram_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb begin
    win = 2'b00;
    if (req[0] && (!req[1] || !ptr)) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end
endmodule

// File: rtl/hbram_host_arbiter.sv
// Two-host burst arbiter for a HyperRAM controller: grant 1 cycle after winning, h_req low >= TURN_CYC+1.
// Backpressure: beats follow h_wrdy/h_rdav; h_mrdy low aborts the burst, h_pause only blocks new grants.
module hbram_host_arbiter #(
  parameter int RAM_DBW  = 8,
  parameter int RAM_ABW  = 25,
  parameter int TURN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   last0,
  input  logic [RAM_ABW-1:0]     addr0,
  input  logic                   btype0,
  input  logic                   atype0,
  input  logic                   rwen0,
  input  logic [RAM_DBW/4-1:0]   wdm0,
  input  logic [2*RAM_DBW-1:0]   wdata0,
  output logic                   gnt0,
  output logic                   wrdy0,
  output logic                   rdav0,
  input  logic                   req1,
  input  logic                   last1,
  input  logic [RAM_ABW-1:0]     addr1,
  input  logic                   btype1,
  input  logic                   atype1,
  input  logic                   rwen1,
  input  logic [RAM_DBW/4-1:0]   wdm1,
  input  logic [2*RAM_DBW-1:0]   wdata1,
  output logic                   gnt1,
  output logic                   wrdy1,
  output logic                   rdav1,
  output logic [2*RAM_DBW-1:0]   rdata,
  output logic                   mrdy,
  output logic                   h_req,
  output logic                   h_last,
  output logic [RAM_ABW-1:0]     h_addr,
  output logic                   h_btype,
  output logic                   h_atype,
  output logic                   h_rwen,
  output logic [RAM_DBW/4-1:0]   h_wdm,
  output logic [2*RAM_DBW-1:0]   h_wdata,
  input  logic                   h_mrdy,
  input  logic                   h_pause,
  input  logic                   h_wrdy,
  input  logic [2*RAM_DBW-1:0]   h_rdata,
  input  logic                   h_rdav
);
  import hbram_pkg::*;

  localparam logic [TURN_W-1:0] GAP_LAST = TURN_W'(TURN_CYC - 1);

  logic [1:0]          state_q, state_d;
  logic                sel_q, sel_d;
  logic                ptr_q, ptr_d;
  logic [TURN_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [RAM_ABW-1:0]  addr_q, addr_d;
  logic                btype_q, btype_d;
  logic                atype_q, atype_d;
  logic                rwen_q, rwen_d;
  logic                mrdy_q, mrdy_d;
  logic [1:0]          win;
  logic                in_burst, in_xfer, final_beat;

  hbram_rr_arb2 u_rr (
    .req ({req1, req0}),
    .ptr (ptr_q),
    .win (win)
  );

  assign in_burst   = (state_q == ST_ISSUE) || (state_q == ST_XFER);
  assign in_xfer    = (state_q == ST_XFER);
  assign final_beat = in_xfer && h_last && (rwen_q ? h_rdav : h_wrdy);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    addr_d    = addr_q;
    btype_d   = btype_q;
    atype_d   = atype_q;
    rwen_d    = rwen_q;
    mrdy_d    = h_mrdy & ~h_pause;
    case (state_q)
      ST_IDLE: begin
        if (h_mrdy && !h_pause && (win != 2'b00)) begin
          state_d = ST_ISSUE;
          sel_d   = win[1];
          addr_d  = win[1] ? addr1  : addr0;
          btype_d = win[1] ? btype1 : btype0;
          atype_d = win[1] ? atype1 : atype0;
          rwen_d  = win[1] ? rwen1  : rwen0;
        end
      end
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER: begin
        // Losing the controller mid-burst ends it just like a normal last beat.
        if (!h_mrdy || final_beat) begin
          state_d   = ST_GAP;
          ptr_d     = ~sel_q;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      ptr_q     <= 1'b0;
      gap_cnt_q <= '0;
      addr_q    <= '0;
      btype_q   <= 1'b0;
      atype_q   <= 1'b0;
      rwen_q    <= 1'b0;
      mrdy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      addr_q    <= addr_d;
      btype_q   <= btype_d;
      atype_q   <= atype_d;
      rwen_q    <= rwen_d;
      mrdy_q    <= mrdy_d;
    end
  end

  assign h_req   = in_burst;
  assign h_addr  = addr_q;
  assign h_btype = btype_q;
  assign h_atype = atype_q;
  assign h_rwen  = rwen_q;
  assign h_last  = in_xfer & (sel_q ? last1 : last0);
  assign h_wdm   = in_xfer ? (sel_q ? wdm1 : wdm0) : '0;
  assign h_wdata = in_xfer ? (sel_q ? wdata1 : wdata0) : '0;

  assign gnt0  = in_burst & ~sel_q;
  assign gnt1  = in_burst &  sel_q;
  assign wrdy0 = in_xfer & ~sel_q & h_wrdy;
  assign wrdy1 = in_xfer &  sel_q & h_wrdy;
  assign rdav0 = in_xfer & ~sel_q & h_rdav;
  assign rdav1 = in_xfer &  sel_q & h_rdav;
  assign rdata = h_rdata;
  assign mrdy  = mrdy_q;
endmodule

// File: tb/tb_hbram_host_arbiter.sv
// Directed bench for hbram_host_arbiter with hand-computed expectations.
module tb_hbram_host_arbiter;
  localparam int DBW = 8;
  localparam int ABW = 25;
  localparam int TC  = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0, last0, btype0, atype0, rwen0;
  logic req1, last1, btype1, atype1, rwen1;
  logic [ABW-1:0] addr0, addr1;
  logic [DBW/4-1:0] wdm0, wdm1;
  logic [2*DBW-1:0] wdata0, wdata1;
  logic gnt0, wrdy0, rdav0, gnt1, wrdy1, rdav1;
  logic [2*DBW-1:0] rdata;
  logic mrdy;
  logic h_req, h_last, h_btype, h_atype, h_rwen;
  logic [ABW-1:0] h_addr;
  logic [DBW/4-1:0] h_wdm;
  logic [2*DBW-1:0] h_wdata;
  logic h_mrdy, h_pause, h_wrdy, h_rdav;
  logic [2*DBW-1:0] h_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hbram_host_arbiter #(.RAM_DBW(DBW), .RAM_ABW(ABW), .TURN_CYC(TC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .last0(last0), .addr0(addr0), .btype0(btype0), .atype0(atype0),
    .rwen0(rwen0), .wdm0(wdm0), .wdata0(wdata0), .gnt0(gnt0), .wrdy0(wrdy0), .rdav0(rdav0),
    .req1(req1), .last1(last1), .addr1(addr1), .btype1(btype1), .atype1(atype1),
    .rwen1(rwen1), .wdm1(wdm1), .wdata1(wdata1), .gnt1(gnt1), .wrdy1(wrdy1), .rdav1(rdav1),
    .rdata(rdata), .mrdy(mrdy),
    .h_req(h_req), .h_last(h_last), .h_addr(h_addr), .h_btype(h_btype), .h_atype(h_atype),
    .h_rwen(h_rwen), .h_wdm(h_wdm), .h_wdata(h_wdata),
    .h_mrdy(h_mrdy), .h_pause(h_pause), .h_wrdy(h_wrdy), .h_rdata(h_rdata), .h_rdav(h_rdav)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    int n;
    n = 0;
    g = {gnt1, gnt0};
    while (g == 2'b00 && n < 40) begin
      step();
      n++;
      g = {gnt1, gnt0};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    int err, cnt, ngr, low, rdsum, ord_err, low_err;
    logic prev;

    rst = 1'b1;
    {req0, last0, btype0, atype0, rwen0, req1, last1, btype1, atype1, rwen1} = '0;
    addr0 = '0; addr1 = '0; wdm0 = '0; wdm1 = '0; wdata0 = '0; wdata1 = '0;
    h_mrdy = 1'b0; h_pause = 1'b0; h_wrdy = 1'b1; h_rdav = 1'b1; h_rdata = '0;

    // Reset state
    step(); step();
    chk("rst_hreq_gnt", {h_req, gnt1, gnt0}, 3'b000);
    chk("rst_wrdy_rdav", {wrdy0, wrdy1, rdav0, rdav1}, 4'b0000);
    chk("rst_mrdy", mrdy, 1'b0);
    chk("rst_haddr", h_addr, 25'h0);
    rst = 1'b0; h_wrdy = 1'b0; h_rdav = 1'b0; h_mrdy = 1'b1;
    #1;
    chk("mrdy_before_edge", mrdy, 1'b0);
    step();
    chk("mrdy_after_edge", mrdy, 1'b1);

    // Single 4-beat write from port 0, one stall beat, req0 dropped mid-burst
    req0 = 1'b1; addr0 = 25'h1234567; btype0 = 1'b1; atype0 = 1'b0; rwen0 = 1'b0;
    #1;
    chk("t1_hreq_win_cycle", h_req, 1'b0);
    step();
    chk("t1_issue", {h_req, gnt1, gnt0}, 3'b101);
    chk("t1_haddr", h_addr, 25'h1234567);
    chk("t1_attr", {h_btype, h_atype, h_rwen}, 3'b100);
    addr0 = 25'h0000F0F;
    step();
    err = 0; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      h_wrdy = (i != 1);
      last0  = (i == 4);
      wdata0 = 16'hA000 + 16'(i);
      wdm0   = 2'(i);
      if (i == 2) req0 = 1'b0;
      #1;
      if (wrdy0 !== h_wrdy || wrdy1 !== 1'b0) err++;
      if (h_wdata !== wdata0 || h_wdm !== wdm0 || h_last !== last0) err++;
      if (h_addr !== 25'h1234567 || gnt0 !== 1'b1 || h_req !== 1'b1) err++;
      if (wrdy0 === 1'b1) cnt++;
      step();
    end
    chk("t1_xfer_routing", err, 0);
    chk("t1_wrdy_beats", cnt, 4);
    h_wrdy = 1'b0; last0 = 1'b0;
    err = 0;
    for (int i = 0; i < TC; i++) begin
      if (h_req !== 1'b0 || gnt0 !== 1'b0 || h_addr !== 25'h1234567) err++;
      step();
    end
    chk("t1_gap_low", err, 0);

    // Both ports requesting continuously: 1-beat reads, strict alternation
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; rwen0 = 1'b1; rwen1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
    h_rdav = 1'b1; addr0 = 25'h0000100; addr1 = 25'h0000200;
    #1;
    ngr = 0; low = 0; rdsum = 0; ord_err = 0; low_err = 0; err = 0; prev = h_req;
    for (int c = 0; c < 40; c++) begin
      if (h_req && !prev) begin
        if (ngr > 0 && low != TC + 1) low_err++;
        if (ngr < 4) begin
          if ({gnt1, gnt0} !== ((ngr % 2 == 0) ? 2'b01 : 2'b10)) ord_err++;
          if (h_addr !== (gnt1 ? 25'h0000200 : 25'h0000100)) ord_err++;
        end
        ngr++;
        low = 0;
      end
      if (!h_req) low++;
      if ((gnt0 && gnt1) || (rdav0 && rdav1)) err++;
      rdsum += int'(rdav0) + int'(rdav1);
      prev = h_req;
      step();
    end
    chk("t2_rr_order", ord_err, 0);
    chk("t2_min_low_gap", low_err, 0);
    chk("t2_grant_count", ngr, 6);
    chk("t2_rdav_count", rdsum, 6);
    chk("t2_onehot", err, 0);

    // Pause in IDLE blocks the grant; release grants 1 cycle later
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b0; req1 = 1'b1; rwen1 = 1'b1; last1 = 1'b0; last0 = 1'b0;
    h_rdav = 1'b0; h_pause = 1'b1; addr1 = 25'h1ABCDEF;
    err = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (h_req !== 1'b0 || gnt1 !== 1'b0) err++;
    end
    chk("t3_paused_no_req", err, 0);
    chk("t3_mrdy_paused", mrdy, 1'b0);
    h_pause = 1'b0;
    #1;
    chk("t3_release_cycle", h_req, 1'b0);
    step();
    chk("t3_issue", {h_req, gnt1, gnt0}, 3'b110);
    chk("t3_mrdy_resume", mrdy, 1'b1);

    // Pause mid-read: burst completes, then no new grant while paused
    step();
    h_pause = 1'b1;
    err = 0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      h_rdav  = (i != 1);
      last1   = (i == 3);
      h_rdata = 16'h5A00 + 16'(i);
      #1;
      if (rdata !== h_rdata || rdav0 !== 1'b0 || gnt1 !== 1'b1 || h_req !== 1'b1) err++;
      if (rdav1 === 1'b1) cnt++;
      step();
    end
    chk("t4_read_routing", err, 0);
    chk("t4_rdav_count", cnt, 3);
    h_rdav = 1'b0; last1 = 1'b0;
    err = 0;
    for (int i = 0; i < 12; i++) begin
      if (h_req !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) err++;
      step();
    end
    chk("t4_paused_after", err, 0);
    req1 = 1'b0; h_pause = 1'b0;
    step(); step();

    // Reset in XFER: outputs drop at once and the pointer returns to port 0
    req0 = 1'b1; rwen0 = 1'b0; last0 = 1'b1; h_wrdy = 1'b1; addr0 = 25'h00ABCDE;
    wait_gnt(g);
    chk("t5_gnt_port0", g, 2'b01);
    req0 = 1'b0;
    step(); step();
    req1 = 1'b1; rwen1 = 1'b0; last1 = 1'b0;
    wait_gnt(g);
    chk("t5_gnt_port1", g, 2'b10);
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    chk("t5_rst_outputs", {h_req, gnt1, gnt0}, 3'b000);
    chk("t5_rst_haddr", h_addr, 25'h0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; last0 = 1'b0;
    wait_gnt(g);
    chk("t5_ptr_reset", g, 2'b01);

    // h_mrdy drop in XFER ends the burst; IDLE holds until h_mrdy returns
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    h_mrdy = 1'b0;
    step();
    chk("t6_mrdy_drop", {h_req, gnt1, gnt0}, 3'b000);
    req1 = 1'b1;
    err = 0;
    for (int i = 0; i < 12; i++) begin
      if (h_req !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) err++;
      step();
    end
    chk("t6_hold_idle", err, 0);
    chk("t6_mrdy_low", mrdy, 1'b0);
    h_mrdy = 1'b1;
    #1;
    chk("t6_resume_cycle", h_req, 1'b0);
    step();
    chk("t6_resume_grant", {h_req, gnt1, gnt0}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
